// File: rtl/axi_burst_master_v2_if.sv
// Command, local data streams and AXI AW/W/B/AR/R signals of the burst master.
// master modport is the burst-master side; slave modport is the controller/AXI-slave side.
interface axi_burst_master_v2_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic [2:0]        cmd_size;
    logic [1:0]        cmd_burst;
    logic              cmd_err;

    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              rd_ready;

    logic              done;
    logic [1:0]        resp;
    logic              proto_err;

    logic [ADDR_W-1:0] AWADDR;
    logic [7:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_size, cmd_burst,
        input  wr_data, wr_valid, rd_ready,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID,
        output cmd_ready, cmd_err, wr_ready, rd_data, rd_valid, rd_last, done, resp, proto_err,
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_size, cmd_burst,
        output wr_data, wr_valid, rd_ready,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID,
        input  cmd_ready, cmd_err, wr_ready, rd_data, rd_valid, rd_last, done, resp, proto_err,
        input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY
    );
endinterface

// File: rtl/axi_burst_master_v2.sv
// Single-outstanding AXI burst master: command -> AW/W/B or AR/R burst, one cycle to address phase.
// W/R data pass straight through, so local and AXI backpressure propagate combinationally both ways.
module axi_burst_master_v2 #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    axi_burst_master_v2_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1;
    localparam logic [STRB_W:0] LSB1 = {{STRB_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len, r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst, r_resp, r_racc;
    logic              r_done, r_cmd_err, r_proto_err;

    // Command legality, evaluated on the live command during the accept cycle
    logic [7:0]        w_cmd_bytes;
    logic [11:0]       w_start_off;
    logic [31:0]       w_end;
    logic              w_wrap_len_bad, w_illegal, w_cmd_rdy, w_accept;

    assign w_cmd_bytes    = 8'd1 << bus.cmd_size;
    assign w_start_off    = bus.cmd_addr[11:0] & ~(12'(w_cmd_bytes) - 12'd1);
    assign w_end          = 32'(w_start_off) + ((32'(bus.cmd_len) + 32'd1) << bus.cmd_size);
    assign w_wrap_len_bad = (bus.cmd_len != 8'd1) && (bus.cmd_len != 8'd3) &&
                            (bus.cmd_len != 8'd7) && (bus.cmd_len != 8'd15);
    assign w_illegal = (32'(w_cmd_bytes) > 32'(STRB_W))
                    || (32'(bus.cmd_len) + 32'd1 > 32'(MAX_LEN))
                    || (bus.cmd_burst == 2'd3)
                    || (bus.cmd_burst == 2'd2 && w_wrap_len_bad)
                    || (bus.cmd_burst == 2'd2 && (bus.cmd_addr[6:0] & (w_cmd_bytes[6:0] - 7'd1)) != 7'd0)
                    || (bus.cmd_burst == 2'd1 && w_end > 32'd4096);
    assign w_cmd_rdy = (r_state == S_IDLE) && !r_done && !r_cmd_err;
    assign w_accept  = bus.cmd_valid && w_cmd_rdy;

    // Beat address generator and lane strobes
    logic [7:0]        w_beat_bytes;
    logic [ADDR_W-1:0] w_size_mask, w_win, w_addr_nxt;
    logic [OFF_W-1:0]  w_lane_raw, w_lane_al;
    logic [STRB_W:0]   w_ones, w_low;
    logic [STRB_W-1:0] w_strb;
    logic              w_beat_hs, w_last_beat;

    assign w_beat_bytes = 8'd1 << r_size;
    assign w_size_mask  = ADDR_W'(w_beat_bytes) - ADDR_W'(1);
    assign w_win        = ADDR_W'((32'(r_len) + 32'd1) << r_size);
    assign w_lane_raw   = r_addr[OFF_W-1:0] & OFF_W'(STRB_W - 1);
    assign w_lane_al    = w_lane_raw & ~OFF_W'(w_beat_bytes - 8'd1);
    assign w_ones       = (LSB1 << w_beat_bytes) - LSB1;
    assign w_low        = (LSB1 << w_lane_raw) - LSB1;
    assign w_last_beat  = (r_cnt == r_len);
    assign w_beat_hs    = (r_state == S_W && bus.wr_valid && bus.WREADY) ||
                          (r_state == S_R && bus.RVALID && bus.rd_ready);

    always_comb begin
        w_addr_nxt = r_addr;
        case (r_burst)
            2'd1:    w_addr_nxt = (r_addr & ~w_size_mask) + ADDR_W'(w_beat_bytes);
            2'd2:    w_addr_nxt = (r_addr & ~(w_win - ADDR_W'(1))) |
                                  ((r_addr + ADDR_W'(w_beat_bytes)) & (w_win - ADDR_W'(1)));
            default: w_addr_nxt = r_addr;
        endcase
        w_strb = w_ones[STRB_W-1:0] << w_lane_al;
        // An unaligned INCR start only owns the bytes from the start address upward
        if (r_burst == 2'd1 && r_cnt == 8'd0)
            w_strb = w_strb & ~w_low[STRB_W-1:0];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bus.AWVALID   = 1'b0;
        bus.WVALID    = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.BREADY    = 1'b0;
        bus.ARVALID   = 1'b0;
        bus.RREADY    = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_last   = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept && !w_illegal) w_next = bus.cmd_write ? S_AW : S_AR;
            S_AW: begin
                bus.AWVALID = 1'b1;
                if (bus.AWREADY) w_next = S_W;
            end
            S_W: begin
                bus.WVALID   = bus.wr_valid;
                bus.wr_ready = bus.WREADY;
                if (w_beat_hs && w_last_beat) w_next = S_B;
            end
            S_B: begin
                bus.BREADY = 1'b1;
                if (bus.BVALID) w_next = S_IDLE;
            end
            S_AR: begin
                bus.ARVALID = 1'b1;
                if (bus.ARREADY) w_next = S_R;
            end
            S_R: begin
                bus.RREADY   = bus.rd_ready;
                bus.rd_valid = bus.RVALID;
                bus.rd_last  = bus.RLAST;
                if (w_beat_hs && (bus.RLAST || w_last_beat)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_resp      <= '0;
            r_racc      <= '0;
            r_done      <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_proto_err <= 1'b0;
            if (w_accept) begin
                r_addr    <= bus.cmd_addr;
                r_len     <= bus.cmd_len;
                r_size    <= bus.cmd_size;
                r_burst   <= bus.cmd_burst;
                r_cnt     <= '0;
                r_racc    <= '0;
                r_cmd_err <= w_illegal;
            end
            if (w_beat_hs) begin
                r_cnt  <= r_cnt + 8'd1;
                r_addr <= w_addr_nxt;
                if (r_state == S_R && r_racc == 2'b00) r_racc <= bus.RRESP;
            end
            if (r_state == S_B && bus.BVALID) begin
                r_done <= 1'b1;
                r_resp <= bus.BRESP;
            end
            if (r_state == S_R && w_beat_hs && (bus.RLAST || w_last_beat)) begin
                r_done      <= 1'b1;
                r_resp      <= (r_racc != 2'b00) ? r_racc : bus.RRESP;
                r_proto_err <= bus.RLAST != w_last_beat;
            end
        end
    end

    assign bus.cmd_ready = w_cmd_rdy;
    assign bus.cmd_err   = r_cmd_err;
    assign bus.done      = r_done;
    assign bus.resp      = r_resp;
    assign bus.proto_err = r_proto_err;
    assign bus.AWADDR    = r_addr;
    assign bus.AWLEN     = r_len;
    assign bus.AWSIZE    = r_size;
    assign bus.AWBURST   = r_burst;
    assign bus.ARADDR    = r_addr;
    assign bus.ARLEN     = r_len;
    assign bus.ARSIZE    = r_size;
    assign bus.ARBURST   = r_burst;
    assign bus.WDATA     = bus.wr_data;
    assign bus.WSTRB     = w_strb;
    assign bus.WLAST     = (r_state == S_W) && w_last_beat;
    assign bus.rd_data   = bus.RDATA;
endmodule
